// File: rtl/keycode_arbiter_pkg.sv
// Shared types and constants for the keyboard direction arbiter:
// direction encoding, default HID codes, dir_held bit positions.
package key_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  localparam logic [7:0] KEY_UP_DEF    = 8'h1A;
  localparam logic [7:0] KEY_DOWN_DEF  = 8'h16;
  localparam logic [7:0] KEY_LEFT_DEF  = 8'h04;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'h07;

  localparam int unsigned IDX_UP    = 0;
  localparam int unsigned IDX_DOWN  = 1;
  localparam int unsigned IDX_LEFT  = 2;
  localparam int unsigned IDX_RIGHT = 3;

  // Fixed priority UP > DOWN > LEFT > RIGHT; empty mask yields DIR_NONE.
  function automatic dir_t prio_pick(input logic [3:0] m);
    if (m[IDX_UP])    return DIR_UP;
    if (m[IDX_DOWN])  return DIR_DOWN;
    if (m[IDX_LEFT])  return DIR_LEFT;
    if (m[IDX_RIGHT]) return DIR_RIGHT;
    return DIR_NONE;
  endfunction

  function automatic logic [3:0] dir_mask(input dir_t d);
    case (d)
      DIR_UP:    return 4'b0001;
      DIR_DOWN:  return 4'b0010;
      DIR_LEFT:  return 4'b0100;
      DIR_RIGHT: return 4'b1000;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/keycode_arbiter_if.sv
// Keyboard-side and ball-side signals of the keycode arbiter.
interface keycode_arbiter_if;
  logic [31:0] keycode_gpio;
  logic        vsync;
  logic [7:0]  keycode;
  logic        key_valid;
  logic        new_press;
  logic [3:0]  dir_held;

  modport master (
    output keycode_gpio, vsync,
    input  keycode, key_valid, new_press, dir_held
  );

  modport slave (
    input  keycode_gpio, vsync,
    output keycode, key_valid, new_press, dir_held
  );
endinterface

// File: rtl/keycode_arbiter_debounce.sv
// Per-direction frame debouncer: saturating hold counter advanced on frame ticks,
// cleared on the first tick the key is absent.
module key_debounce #(
  parameter int unsigned DEBOUNCE_FRAMES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tick,
  input  logic raw,
  output logic held,
  output logic held_next
);

  localparam logic [2:0] LIMIT = 3'(DEBOUNCE_FRAMES);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      if (!raw)
        cnt_d = '0;
      else if (cnt_q != LIMIT)
        cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign held      = (cnt_q == LIMIT);
  assign held_next = (cnt_d == LIMIT);

endmodule

// File: rtl/keycode_arbiter.sv
// Turns a 4-slot HID keycode report into one debounced, recency-arbitrated
// movement keycode that only changes on vsync rising edges.
module keycode_arbiter
  import key_pkg::*;
#(
  parameter logic [7:0]  KEY_UP          = KEY_UP_DEF,
  parameter logic [7:0]  KEY_DOWN        = KEY_DOWN_DEF,
  parameter logic [7:0]  KEY_LEFT        = KEY_LEFT_DEF,
  parameter logic [7:0]  KEY_RIGHT       = KEY_RIGHT_DEF,
  parameter int unsigned DEBOUNCE_FRAMES = 2
) (
  input logic               Clk,
  input logic               Reset,
  keycode_arbiter_if.slave  kb
);

  logic       s1_q, s2_q, s3_q;
  logic       tick;
  logic [3:0] raw, held, held_next, newly;
  dir_t       act_q, act_d;
  logic [7:0] keycode_q, keycode_d;
  logic       new_press_q, new_press_d;

  // Flops reset high so a vsync already high at release does not look like an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= kb.vsync;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (kb.keycode_gpio[8*i +: 8] != 8'h00) begin
        if (kb.keycode_gpio[8*i +: 8] == KEY_UP)    raw[IDX_UP]    = 1'b1;
        if (kb.keycode_gpio[8*i +: 8] == KEY_DOWN)  raw[IDX_DOWN]  = 1'b1;
        if (kb.keycode_gpio[8*i +: 8] == KEY_LEFT)  raw[IDX_LEFT]  = 1'b1;
        if (kb.keycode_gpio[8*i +: 8] == KEY_RIGHT) raw[IDX_RIGHT] = 1'b1;
      end
    end
  end

  for (genvar d = 0; d < 4; d++) begin : g_deb
    key_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
      .Clk       (Clk),
      .Reset     (Reset),
      .tick      (tick),
      .raw       (raw[d]),
      .held      (held[d]),
      .held_next (held_next[d])
    );
  end

  assign newly = held_next & ~held;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      act_q       <= DIR_NONE;
      keycode_q   <= '0;
      new_press_q <= 1'b0;
    end else begin
      act_q       <= act_d;
      keycode_q   <= keycode_d;
      new_press_q <= new_press_d;
    end
  end

  // Recency first, then keep the current choice, then fixed priority.
  always_comb begin
    act_d = act_q;
    if (tick) begin
      if (|newly)
        act_d = prio_pick(newly);
      else if ((held_next & dir_mask(act_q)) != 4'b0000)
        act_d = act_q;
      else
        act_d = prio_pick(held_next);
    end

    case (act_d)
      DIR_UP:    keycode_d = KEY_UP;
      DIR_DOWN:  keycode_d = KEY_DOWN;
      DIR_LEFT:  keycode_d = KEY_LEFT;
      DIR_RIGHT: keycode_d = KEY_RIGHT;
      default:   keycode_d = 8'h00;
    endcase

    new_press_d = (act_d != act_q) && (act_d != DIR_NONE);
  end

  assign kb.keycode   = keycode_q;
  assign kb.key_valid = (keycode_q != 8'h00);
  assign kb.new_press = new_press_q;
  assign kb.dir_held  = held;

endmodule

// File: tb/tb_keycode_arbiter.sv
// Bench for keycode_arbiter: directed frame table, reset sequences and random
// frames checked against a frame-level model of the arbitration rules.
module tb_keycode_arbiter;

  localparam int DF = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  keycode_arbiter_if bus ();

  keycode_arbiter #(.DEBOUNCE_FRAMES(DF)) dut (
    .Clk   (clk),
    .Reset (rst),
    .kb    (bus)
  );

  typedef struct {
    logic [31:0] gpio;
    logic [7:0]  kc;
    logic [3:0]  held;
    int          pulses;
  } vec_t;

  vec_t tbl[15];

  logic [7:0] codes[4];
  int         run[4];
  int         m_act;
  int         m_pulse;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++) run[d] = 0;
    m_act = 0;
    m_pulse = 0;
  endtask

  // One frame tick of the model: run lengths of consecutive frames per direction.
  task automatic model_tick(input logic [31:0] g);
    bit prev[4], now[4];
    int nxt, fresh;
    for (int d = 0; d < 4; d++) begin
      bit present = 0;
      for (int s = 0; s < 4; s++)
        if (g[8*s +: 8] == codes[d]) present = 1;
      prev[d] = (run[d] == DF);
      run[d]  = present ? ((run[d] < DF) ? run[d] + 1 : DF) : 0;
      now[d]  = (run[d] == DF);
    end
    fresh = -1;
    for (int d = 3; d >= 0; d--) if (now[d] && !prev[d]) fresh = d;
    if (fresh >= 0) nxt = fresh + 1;
    else if (m_act != 0 && now[m_act-1]) nxt = m_act;
    else begin
      nxt = 0;
      for (int d = 3; d >= 0; d--) if (now[d]) nxt = d + 1;
    end
    m_pulse = (nxt != m_act && nxt != 0) ? 1 : 0;
    m_act = nxt;
  endtask

  function automatic logic [7:0] model_kc();
    return (m_act == 0) ? 8'h00 : codes[m_act-1];
  endfunction

  function automatic logic [3:0] model_held();
    logic [3:0] h;
    for (int d = 0; d < 4; d++) h[d] = (run[d] == DF);
    return h;
  endfunction

  // vsync low for lo cycles with garbage on gpio, then g with vsync high for hi cycles.
  task automatic do_frame(input logic [31:0] g, input int lo, input int hi, output int pulses);
    pulses = 0;
    bus.keycode_gpio = $urandom;
    bus.vsync = 1'b0;
    repeat (lo) begin
      @(negedge clk);
      if (bus.new_press) pulses++;
    end
    bus.keycode_gpio = g;
    bus.vsync = 1'b1;
    repeat (hi) begin
      @(negedge clk);
      if (bus.new_press) pulses++;
    end
    model_tick(g);
  endtask

  task automatic chk_outputs(input string tag, input logic [7:0] kc, input logic [3:0] h, input int p, input int pulses);
    chk({tag, ".keycode"},   {24'h0, bus.keycode}, {24'h0, kc});
    chk({tag, ".key_valid"}, {31'h0, bus.key_valid}, {31'h0, (kc != 8'h00)});
    chk({tag, ".dir_held"},  {28'h0, bus.dir_held}, {28'h0, h});
    chk({tag, ".new_press"}, pulses, p);
  endtask

  initial begin
    int p;
    logic [31:0] g;
    bit pressed[4];

    codes[0] = 8'h1A; codes[1] = 8'h16; codes[2] = 8'h04; codes[3] = 8'h07;

    tbl[0]  = '{32'h0000001A, 8'h00, 4'b0000, 0};
    tbl[1]  = '{32'h0000001A, 8'h1A, 4'b0001, 1};
    tbl[2]  = '{32'h00000000, 8'h00, 4'b0000, 0};
    tbl[3]  = '{32'h0000001A, 8'h00, 4'b0000, 0};
    tbl[4]  = '{32'h00000000, 8'h00, 4'b0000, 0};
    tbl[5]  = '{32'h00000004, 8'h00, 4'b0000, 0};
    tbl[6]  = '{32'h00000004, 8'h04, 4'b0100, 1};
    tbl[7]  = '{32'h00000704, 8'h04, 4'b0100, 0};
    tbl[8]  = '{32'h00000704, 8'h07, 4'b1100, 1};
    tbl[9]  = '{32'h00000004, 8'h04, 4'b0100, 1};
    tbl[10] = '{32'h00000000, 8'h00, 4'b0000, 0};
    tbl[11] = '{32'h2C00161A, 8'h00, 4'b0000, 0};
    tbl[12] = '{32'h2C00161A, 8'h1A, 4'b0011, 1};
    tbl[13] = '{32'h1A1A1A1A, 8'h1A, 4'b0001, 0};
    tbl[14] = '{32'h00000000, 8'h00, 4'b0000, 0};

    model_reset();
    rst = 1'b1;
    bus.keycode_gpio = 32'h0000001A;
    bus.vsync = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bus.vsync = ~bus.vsync;
    end
    bus.vsync = 1'b1;
    chk_outputs("reset", 8'h00, 4'b0000, 0, {31'h0, bus.new_press});
    rst = 1'b0;

    // vsync already high at release: holding it must not produce a tick.
    p = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.new_press) p++;
    end
    chk_outputs("post_reset", 8'h00, 4'b0000, 0, p);

    for (int i = 0; i < 15; i++) begin
      do_frame(tbl[i].gpio, 3, 3, p);
      chk_outputs($sformatf("vec%0d", i), tbl[i].kc, tbl[i].held, tbl[i].pulses, p);
    end

    // Mid-hold reset then fresh re-acceptance.
    do_frame(32'h00000007, 2, 4, p);
    do_frame(32'h00000007, 2, 4, p);
    chk_outputs("hold07", 8'h07, 4'b1000, 1, p);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_outputs("midreset", 8'h00, 4'b0000, 0, {31'h0, bus.new_press});
    do_frame(32'h00000007, 2, 4, p);
    chk_outputs("reacc1", 8'h00, 4'b0000, 0, p);
    do_frame(32'h00000007, 2, 4, p);
    chk_outputs("reacc2", 8'h07, 4'b1000, 1, p);

    for (int d = 0; d < 4; d++) pressed[d] = 0;
    for (int f = 0; f < 250; f++) begin
      int rot;
      for (int d = 0; d < 4; d++)
        if ($urandom_range(0, 3) == 0) pressed[d] = ~pressed[d];
      rot = $urandom_range(0, 3);
      g = '0;
      for (int d = 0; d < 4; d++) begin
        int s = (d + rot) % 4;
        if (pressed[d]) g[8*s +: 8] = codes[d];
        else case ($urandom_range(0, 3))
          0: g[8*s +: 8] = 8'h2C;
          1: g[8*s +: 8] = 8'($urandom);
          default: g[8*s +: 8] = 8'h00;
        endcase
      end
      do_frame(g, $urandom_range(1, 5), $urandom_range(3, 6), p);
      chk_outputs($sformatf("rnd%0d", f), model_kc(), model_held(), m_pulse, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_arbiter.md
# keycode_arbiter

Turns the raw USB HID keyboard report into the single, frame-stable movement keycode that the ball motion block consumes. It sits between the keycode GPIO of the MicroBlaze/USB subsystem and the ball block's `keycode` input. Per frame it:
- debounces each direction key,
- resolves simultaneous presses by recency, then by fixed priority,
- presents one 8-bit keycode that changes only at frame boundaries.

## Interface
Parameters:
- `KEY_UP`, default 8'h1A: HID code for up (W)
- `KEY_DOWN`, default 8'h16: HID code for down (S)
- `KEY_LEFT`, default 8'h04: HID code for left (A)
- `KEY_RIGHT`, default 8'h07: HID code for right (D)
- `DEBOUNCE_FRAMES`, default 2: consecutive frame ticks a key must be held before it is accepted (legal range 1–7)

Ports:
- `Clk`, in, 1: system clock. One clock; reset is synchronous and active-high.
- `Reset`, in, 1: synchronous, active-high.
- `keycode_gpio`, in, 32: four HID keycode slots; slot0=[7:0] … slot3=[31:24]; 8'h00 means empty.
- `vsync`, in, 1: frame signal (the ball's frame_clk), asynchronous to `Clk`.
- `keycode`, out, 8: arbitrated movement keycode to the ball block; 8'h00 when idle.
- `key_valid`, out, 1: high while `keycode` is non-zero.
- `new_press`, out, 1: one-`Clk` pulse when the active direction changes to a non-idle value.
- `dir_held`, out, 4: debounced held flags; [0]=UP, [1]=DOWN, [2]=LEFT, [3]=RIGHT.

## Operation
- **Frame tick:** `vsync` passes through sync flops s1, s2, then edge flop s3. `tick = s2 & ~s3`. All three flops reset to 1, so no tick fires unless a low→high transition is seen after reset.
- **Raw detect (every cycle):** `raw[d] = 1` if any slot equals code d. Duplicate slots count once. Codes that match no direction, and 8'h00, are ignored.
- **Debounce:** one 3-bit counter per direction, updated only on tick.
  - If `raw[d]`: increment, saturating at DEBOUNCE_FRAMES.
  - Otherwise: clear to 0.
  - `dir_held[d] = (cnt[d] == DEBOUNCE_FRAMES)`.
  - Result: acceptance takes DEBOUNCE_FRAMES ticks; release takes effect on the first tick.
- **Active direction** (`dir_t` register, updated on tick from next-state held flags):
  - If one or more directions newly became held on this tick, the newest wins. Ties among newly held directions go to fixed priority UP > DOWN > LEFT > RIGHT.
  - Otherwise, if the current active direction is still held, keep it.
  - Otherwise, take the highest fixed-priority held direction.
  - Otherwise, DIR_NONE.
- **Output:** `keycode` is the parameter code of the active direction, or 8'h00 for DIR_NONE. `key_valid = (keycode != 0)`.
- **`new_press`:** asserted for the one cycle following the update edge when the active direction changed and the new value is not DIR_NONE. A change to DIR_NONE produces no pulse.
- **Reset values:** `keycode`=8'h00, `key_valid`=0, `new_press`=0, `dir_held`=4'b0000, all counters 0, active=DIR_NONE.
- **Reset mid-operation:** all state clears at the next edge, regardless of `vsync` or `keycode_gpio`.

## Timing
- `vsync` sampled high at edge k → tick high in the cycle between edges k+1 and k+2 → counters, `dir_held`, active direction, `keycode` and `new_press` all update at edge k+2.
- `keycode` is constant between ticks, so the ball block always samples a stable value on its `frame_clk` edge.
- If `vsync` stays high, only one tick fires. `vsync` pulses shorter than one `Clk` period are not guaranteed to be detected.
- `keycode_gpio` is used only in the tick cycle. Changes between ticks are ignored, so no synchronizer is required on it.

## Structure
- Shared package `key_pkg`:
  - `dir_t` enum {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - default HID code constants
  - direction index constants for `dir_held` bit positions
- Sub-module `key_debounce`, instantiated 4×:
  - inputs: `Clk`, `Reset`, `tick`, `raw`
  - output: `held`, plus the next-state `held_next` consumed by the arbiter logic
  - parameter: `DEBOUNCE_FRAMES`
- Top level holds the vsync sync/edge flops, raw-detect compare, active-direction register and output registers.

## Test plan
All scenarios use DEBOUNCE_FRAMES=2.
1. **Reset:** `Reset` high 3 cycles with `vsync` toggling and `keycode_gpio`=32'h0000001A → `keycode`=8'h00, `key_valid`=0, `new_press`=0, `dir_held`=0000. With `vsync` already high at reset release, no tick fires until `vsync` falls and rises again.
2. **Accept:** `keycode_gpio`=32'h0000001A held.
   - After tick 1: `keycode`=8'h00.
   - After tick 2: `keycode`=8'h1A, `key_valid`=1, `dir_held`=0001, `new_press` high exactly one cycle.
3. **Glitch rejection:** 8'h1A present for exactly one tick, then 32'h0 → `keycode` stays 8'h00 and `new_press` never pulses.
4. **Recency:**
   - Hold 32'h00000004 → `keycode`=8'h04.
   - Then 32'h00000704 → two ticks later `keycode`=8'h07, with a `new_press` pulse.
   - Then 32'h00000004 → on the next tick `keycode`=8'h04, with a `new_press` pulse.
   - Then 32'h0 → on the next tick `keycode`=8'h00, no pulse.
5. **Simultaneous and unknown codes:** 32'h2C00161A applied from idle → after two ticks `keycode`=8'h1A (UP beats DOWN), `dir_held`=0011, and 8'h2C has no effect.
6. **Mid-hold reset:** with `keycode`=8'h07 stable, assert `Reset` for 1 cycle → all outputs return to reset values at the next edge. The key must then be re-accepted over two fresh ticks.
